// File: rtl/sbox_sub_word.sv
// Two-stage AES SubBytes/SubWord engine: S1 captures the word, S2 holds the per-lane S-box lookup.
// Optional macro SBOX_SUB_WORD_INV_EN adds the inverse S-box, selected per word by in_inv. BYTE must be 8.
module sbox_sub_word #(
    parameter int unsigned BYTE  = 8,
    parameter int unsigned LANES = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*BYTE-1:0]   in_data,
    input  logic                    in_inv,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*BYTE-1:0]   out_data,
    output logic                    out_inv,
    output logic                    busy,
    output logic [CNT_W-1:0]        done_cnt
);

    localparam int unsigned W = LANES * BYTE;

    // Forward AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        return SBOX[(255 - 32'(x)) * 8 +: 8];
    endfunction

`ifdef SBOX_SUB_WORD_INV_EN
    // Inverse table derived by matching against the forward table; every index has exactly one preimage.
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] r;
        r = '0;
        for (int j = 0; j < 256; j++) begin
            if (SBOX[(255 - j) * 8 +: 8] == x) r = 8'(j);
        end
        return r;
    endfunction
`endif

    logic           s1_valid;
    logic [W-1:0]   s1_data;
    logic           s1_inv;
    logic [W-1:0]   lut;
    logic           adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign busy     = s1_valid | out_valid;

    // Per-lane substitution of the S1 word; all lanes share the mode bit.
    always_comb begin
        lut = '0;
        for (int i = 0; i < int'(LANES); i++) begin
`ifdef SBOX_SUB_WORD_INV_EN
            lut[i*BYTE +: BYTE] = s1_inv ? inv_sbox(s1_data[i*BYTE +: BYTE])
                                         : fwd_sbox(s1_data[i*BYTE +: BYTE]);
`else
            lut[i*BYTE +: BYTE] = fwd_sbox(s1_data[i*BYTE +: BYTE]);
`endif
        end
    end

    // Both stages shift together on adv; payload registers load only with valid data so bubbles hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_inv    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_inv   <= 1'b0;
            done_cnt  <= '0;
        end else begin
            if (adv) begin
                s1_valid  <= in_valid;
                out_valid <= s1_valid;
                if (in_valid) begin
                    s1_data <= in_data;
                    s1_inv  <= in_inv;
                end
                if (s1_valid) begin
                    out_data <= lut;
                    out_inv  <= s1_inv;
                end
            end
            if (out_valid && out_ready) done_cnt <= done_cnt + CNT_W'(1);
        end
    end

endmodule
